upsampler_2x: RTL and testbench

UPSAMPLER_2X -- requirements
Module: upsampler_2x

---
 rtl/upsampler_2x.sv | 114 +++++++++++
 tb/tb_upsampler_2x.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/upsampler_2x.sv
// rtl/upsampler_2x.sv - 2x nearest-neighbour upsampler: each pixel twice per row, each row twice
// LIVE pops from a FWFT FIFO and fills the line buffer; REPLAY re-emits the buffered row.
module upsampler_2x #(
  parameter int IN_WIDTH = 420,
  parameter int DATA_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] dataout,
  output logic              validout,
  output logic              fifo_read
);

  localparam int XW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);

  typedef enum logic {
    LIVE   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic              phase_q, phase_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              validout_q, validout_d;

  logic [DATA_W-1:0] line_buf [IN_WIDTH];
  logic [DATA_W-1:0] prefetch_q;
  logic [XW-1:0]     rd_addr;
  logic              wr_en;
  logic              pop;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    phase_d    = phase_q;
    dataout_d  = dataout_q;
    validout_d = 1'b0;
    pop        = 1'b0;
    wr_en      = 1'b0;
    rd_addr    = '0;
    case (state_q)
      LIVE: begin
        if (!phase_q) begin
          pop = valid;
          if (valid) begin
            dataout_d  = data;
            validout_d = 1'b1;
            wr_en      = 1'b1;
            phase_d    = 1'b1;
          end
        end else begin
          validout_d = 1'b1;
          phase_d    = 1'b0;
          if (x_q == X_LAST) begin
            x_d     = '0;
            state_d = REPLAY;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      REPLAY: begin
        // prefetch_q always holds the pixel due on the next edge, so the read address leads by one cycle
        dataout_d  = prefetch_q;
        validout_d = 1'b1;
        phase_d    = ~phase_q;
        if (!phase_q) begin
          rd_addr = x_q;
        end else if (x_q == X_LAST) begin
          rd_addr = '0;
          x_d     = '0;
          state_d = LIVE;
        end else begin
          rd_addr = x_q + 1'b1;
          x_d     = x_q + 1'b1;
        end
      end
      default: state_d = LIVE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= LIVE;
      x_q        <= '0;
      phase_q    <= 1'b0;
      dataout_q  <= '0;
      validout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      phase_q    <= phase_d;
      dataout_q  <= dataout_d;
      validout_q <= validout_d;
    end
  end

  // While LIVE the read port parks on column 0, so the first REPLAY pixel is ready on entry
  always_ff @(posedge clock) begin
    if (wr_en) begin
      line_buf[x_q] <= data;
    end
    prefetch_q <= line_buf[rd_addr];
  end

  assign fifo_read = pop & reset;
  assign dataout   = dataout_q;
  assign validout  = validout_q;

endmodule

// File: tb/tb_upsampler_2x.sv
// tb/tb_upsampler_2x.sv - directed vector bench for upsampler_2x
module tb_upsampler_2x;

  logic       clock;
  logic       reset;
  logic       valid;
  logic [7:0] data;
  logic [7:0] dataout;
  logic       validout;
  logic       fifo_read;

  int errors;
  int checks;
  logic       exp_v;
  logic [7:0] exp_d;

  upsampler_2x #(.IN_WIDTH(420), .DATA_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .valid    (valid),
    .data     (data),
    .dataout  (dataout),
    .validout (validout),
    .fifo_read(fifo_read)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       fr;
    logic       vo;
    logic [7:0] dout;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // one clock: drive, check fifo_read and the currently visible output, advance, update expectation
  task automatic cyc(input logic v, input logic [7:0] d, input logic efr,
                     input logic nv, input logic [7:0] nd, input string tag);
    valid = v;
    data  = d;
    @(negedge clock);
    chk({tag, ".fifo_read"}, 8'(fifo_read), 8'(efr));
    chk({tag, ".validout"}, 8'(validout), 8'(exp_v));
    if (exp_v) chk({tag, ".dataout"}, dataout, exp_d);
    @(posedge clock);
    #1;
    exp_v = nv;
    exp_d = nd;
  endtask

  task automatic run_row(input int off, input int stall_col, input int abort_k, input string tag);
    logic [7:0] p;
    for (int col = 0; col < 420; col++) begin
      p = 8'((col + off) & 255);
      if (col == stall_col) begin
        for (int s = 0; s < 5; s++) cyc(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0, exp_d, {tag, ".stall"});
      end
      cyc(1'b1, p, 1'b1, 1'b1, p, {tag, ".live0"});
      cyc(1'b1, ~p, 1'b0, 1'b1, p, {tag, ".live1"});
    end
    for (int k = 0; k < 840; k++) begin
      if (k == abort_k) return;
      p = 8'(((k / 2) + off) & 255);
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 1'b1, p, {tag, ".replay"});
    end
  endtask

  task automatic reset_now(input string tag);
    valid = 1'b1;
    data  = 8'hEE;
    reset = 1'b0;
    #1;
    chk({tag, ".rst_validout"}, 8'(validout), 8'h00);
    chk({tag, ".rst_dataout"}, dataout, 8'h00);
    chk({tag, ".rst_fifo_read"}, 8'(fifo_read), 8'h00);
    repeat (2) @(posedge clock);
    #1;
    chk({tag, ".rst_hold_fifo_read"}, 8'(fifo_read), 8'h00);
    reset = 1'b1;
    exp_v = 1'b0;
    exp_d = 8'h00;
  endtask

  vec_t tbl [11];

  initial begin
    errors = 0;
    checks = 0;
    exp_v  = 1'b0;
    exp_d  = 8'h00;
    reset  = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;

    tbl[0]  = '{v: 1'b0, d: 8'h55, fr: 1'b0, vo: 1'b0, dout: 8'h00};
    tbl[1]  = '{v: 1'b0, d: 8'h55, fr: 1'b0, vo: 1'b0, dout: 8'h00};
    tbl[2]  = '{v: 1'b1, d: 8'h00, fr: 1'b1, vo: 1'b0, dout: 8'h00};
    tbl[3]  = '{v: 1'b1, d: 8'h77, fr: 1'b0, vo: 1'b1, dout: 8'h00};
    tbl[4]  = '{v: 1'b0, d: 8'h33, fr: 1'b0, vo: 1'b1, dout: 8'h00};
    tbl[5]  = '{v: 1'b1, d: 8'h01, fr: 1'b1, vo: 1'b0, dout: 8'h00};
    tbl[6]  = '{v: 1'b1, d: 8'h99, fr: 1'b0, vo: 1'b1, dout: 8'h01};
    tbl[7]  = '{v: 1'b1, d: 8'h02, fr: 1'b1, vo: 1'b1, dout: 8'h01};
    tbl[8]  = '{v: 1'b0, d: 8'h44, fr: 1'b0, vo: 1'b1, dout: 8'h02};
    tbl[9]  = '{v: 1'b0, d: 8'h44, fr: 1'b0, vo: 1'b1, dout: 8'h02};
    tbl[10] = '{v: 1'b0, d: 8'h44, fr: 1'b0, vo: 1'b0, dout: 8'h02};

    #2;
    reset_now("por");

    for (int i = 0; i < 11; i++) begin
      valid = tbl[i].v;
      data  = tbl[i].d;
      @(negedge clock);
      chk($sformatf("tbl%0d.fifo_read", i), 8'(fifo_read), 8'(tbl[i].fr));
      chk($sformatf("tbl%0d.validout", i), 8'(validout), 8'(tbl[i].vo));
      chk($sformatf("tbl%0d.dataout", i), dataout, tbl[i].dout);
      @(posedge clock);
      #1;
    end

    reset_now("live_abort");
    run_row(0, -1, -1, "row0");
    run_row(1, 10, -1, "row1");
    run_row(8'h20, -1, 400, "row2");
    reset_now("replay_abort");
    run_row(8'h50, -1, -1, "row3");
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
